mbus_wire_seq: RTL

Synchronous sequencer for the MBus wire-control isolation mux. It decides when a node pulls DOUT low to request the bus (external interrupt) and when it releases isolation so the bus controller drives DOUT/CLKOUT. It also decides when the node returns to pass-through hold after the bus controller signals sleep. It sits between the layer's interrupt request, the sleep controller and the wire-control mux, and runs on the local system clock.

---
 rtl/mbus_wire_seq_if.sv | 24 ++
 rtl/mbus_wire_seq.sv | 111 +++++++++++
 2 files changed

// File: rtl/mbus_wire_seq_if.sv
// Signal bundle between the wire sequencer and its neighbours: layer interrupt
// request, sleep controller, raw bus pins, and the wire-control mux controls.
interface mbus_wire_seq_if;
  logic MASTER_NODE;
  logic INT_REQ;
  logic SLEEP_REQ;
  logic CLKIN;
  logic DIN;
  logic EXTERNAL_INT;
  logic RELEASE_ISO;
  logic INT_ACK;
  logic TIMEOUT_ERR;
  logic BUSY;

  modport master (
    output MASTER_NODE, INT_REQ, SLEEP_REQ, CLKIN, DIN,
    input  EXTERNAL_INT, RELEASE_ISO, INT_ACK, TIMEOUT_ERR, BUSY
  );

  modport slave (
    input  MASTER_NODE, INT_REQ, SLEEP_REQ, CLKIN, DIN,
    output EXTERNAL_INT, RELEASE_ISO, INT_ACK, TIMEOUT_ERR, BUSY
  );
endinterface

// File: rtl/mbus_wire_seq.sv
// MBus wire-control sequencer: decides when the node pulls DOUT low to wake the
// bus, when isolation is released to the bus controller, and when it re-isolates.
`ifndef IO_HOLD
`define IO_HOLD 1'b1
`endif
`ifndef IO_RELEASE
`define IO_RELEASE 1'b0
`endif

module mbus_wire_seq #(
  parameter int SYNC_STAGES  = 2,
  parameter int WAKE_EDGES   = 2,
  parameter int INT_TIMEOUT  = 1023,
  parameter int GUARD_CYCLES = 4,
  parameter int CNT_W        = 10
) (
  input  logic           CLK,
  input  logic           RESETn,
  mbus_wire_seq_if.slave bus
);
  localparam int EC_W = $clog2(WAKE_EDGES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(INT_TIMEOUT);
  localparam logic [CNT_W-1:0] GUARD_C   = CNT_W'(GUARD_CYCLES);
  localparam logic [EC_W-1:0]  WAKE_C    = EC_W'(WAKE_EDGES);

  typedef enum logic [2:0] {IDLE, INT_ASSERT, RELEASE, ACTIVE, GUARD} state_t;

  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] clk_sync, din_sync;
  logic clk_dly, din_dly, clk_fall, din_fall;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [EC_W-1:0]  edge_cnt, edge_inc;
  logic ack_nxt, terr_nxt;

  // Synchronizers idle high, so reset never manufactures a falling edge.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      clk_sync <= '1;
      din_sync <= '1;
      clk_dly  <= 1'b1;
      din_dly  <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.CLKIN};
      din_sync <= {din_sync[SYNC_STAGES-2:0], bus.DIN};
      clk_dly  <= clk_sync[SYNC_STAGES-1];
      din_dly  <= din_sync[SYNC_STAGES-1];
    end
  end

  assign clk_fall = clk_dly & ~clk_sync[SYNC_STAGES-1];
  assign din_fall = din_dly & ~din_sync[SYNC_STAGES-1];

  // cnt holds (cycles spent in state - 1); cnt_inc is the count including this cycle.
  assign cnt_inc  = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign edge_inc = (clk_fall && edge_cnt != WAKE_C) ? edge_cnt + EC_W'(1) : edge_cnt;

  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    terr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (din_fall) begin
          state_nxt = RELEASE;
        end else if (bus.INT_REQ && bus.MASTER_NODE) begin
          state_nxt = RELEASE;
          ack_nxt   = 1'b1;
        end else if (bus.INT_REQ) begin
          state_nxt = INT_ASSERT;
        end
      end
      INT_ASSERT: begin
        // Wake confirmation beats a simultaneous timeout.
        if (edge_inc == WAKE_C) begin
          state_nxt = RELEASE;
          ack_nxt   = 1'b1;
        end else if (cnt_inc == TIMEOUT_C) begin
          state_nxt = IDLE;
          terr_nxt  = 1'b1;
        end
      end
      RELEASE: state_nxt = ACTIVE;
      ACTIVE:  if (bus.SLEEP_REQ) state_nxt = GUARD;
      GUARD:   if (cnt_inc == GUARD_C) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state            <= IDLE;
      cnt              <= '0;
      edge_cnt         <= '0;
      bus.EXTERNAL_INT <= 1'b0;
      bus.RELEASE_ISO  <= `IO_HOLD;
      bus.INT_ACK      <= 1'b0;
      bus.TIMEOUT_ERR  <= 1'b0;
      bus.BUSY         <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= (state_nxt != state) ? '0 : cnt_inc;
      edge_cnt         <= (state_nxt != state || state != INT_ASSERT) ? '0 : edge_inc;
      bus.EXTERNAL_INT <= (state_nxt == INT_ASSERT);
      bus.RELEASE_ISO  <= (state_nxt == RELEASE || state_nxt == ACTIVE || state_nxt == GUARD)
                          ? `IO_RELEASE : `IO_HOLD;
      bus.INT_ACK      <= ack_nxt;
      bus.TIMEOUT_ERR  <= terr_nxt;
      bus.BUSY         <= (state_nxt != IDLE);
    end
  end
endmodule
